// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480@60 timing constants and
// per-axis helpers shared by the counter and the top.
package vga_pkg;

  localparam int H_ACTIVE_D = 640;
  localparam int H_FP_D     = 16;
  localparam int H_SYNC_D   = 96;
  localparam int H_BP_D     = 48;

  localparam int V_ACTIVE_D = 480;
  localparam int V_FP_D     = 10;
  localparam int V_SYNC_D   = 2;
  localparam int V_BP_D     = 33;

  localparam int CLK_DIV_D  = 2;
  localparam int CNT_W_D    = 10;
  localparam int DIV_W      = 4;

  typedef struct packed {
    logic sync;
    logic active;
  } axis_dec_t;

  function automatic int axis_total(
    input int active,
    input int fp,
    input int sync,
    input int bp
  );
    return active + fp + sync + bp;
  endfunction

  function automatic axis_dec_t axis_decode(
    input int   cnt,
    input int   active,
    input int   fp,
    input int   sync,
    input logic pol
  );
    axis_dec_t d;
    d.active = (cnt < active);
    d.sync   = (cnt >= active + fp &&
                cnt <  active + fp + sync) ? pol : ~pol;
    return d;
  endfunction

endpackage

// File: rtl/vga_axis_ctr.sv
// vga_axis_ctr: one timing axis -- counter, sync and
// active decode registered from the counter's next value.
module vga_axis_ctr
  import vga_pkg::*;
#(
  parameter int   ACTIVE = H_ACTIVE_D,
  parameter int   FP     = H_FP_D,
  parameter int   SYNC   = H_SYNC_D,
  parameter int   BP     = H_BP_D,
  parameter logic POL    = 1'b0,
  parameter int   W      = CNT_W_D
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         adv,
  output logic [W-1:0] cnt,
  output logic         sync,
  output logic         wrap,
  output logic         active_nxt
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
  localparam logic [W-1:0] LAST = W'(TOTAL - 1);

  logic [W-1:0] cnt_nxt;
  axis_dec_t    dec_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (adv) begin
      cnt_nxt = (cnt == LAST) ? '0 : cnt + W'(1);
    end
  end

  assign wrap = adv && (cnt == LAST);

  assign dec_nxt = axis_decode(
    int'(cnt_nxt), ACTIVE, FP, SYNC, POL);

  assign active_nxt = dec_nxt.active;

  // Reset parks on the last count so the first advance lands on 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= LAST;
      sync <= ~POL;
    end else begin
      cnt  <= cnt_nxt;
      sync <= dec_nxt.sync;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing with a pixel strobe
// from a clk divider and two cascaded axis counters.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = H_ACTIVE_D,
  parameter int   H_FP     = H_FP_D,
  parameter int   H_SYNC   = H_SYNC_D,
  parameter int   H_BP     = H_BP_D,
  parameter int   V_ACTIVE = V_ACTIVE_D,
  parameter int   V_FP     = V_FP_D,
  parameter int   V_SYNC   = V_SYNC_D,
  parameter int   V_BP     = V_BP_D,
  parameter logic H_POL    = 1'b0,
  parameter logic V_POL    = 1'b0,
  parameter int   CLK_DIV  = CLK_DIV_D,
  parameter int   CNT_W    = CNT_W_D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             pix_en,
  output logic             h_sync,
  output logic             v_sync,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             video_on,
  output logic             line_start,
  output logic             frame_start
);

  localparam int H_TOTAL =
    axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL =
    axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_TOTAL > (1 << CNT_W)) begin : g_h_total_chk
    $error("H_TOTAL does not fit in CNT_W");
  end
  if (V_TOTAL > (1 << CNT_W)) begin : g_v_total_chk
    $error("V_TOTAL does not fit in CNT_W");
  end
  if (H_BP == 0 || H_SYNC == 0) begin : g_h_zero_chk
    $error("H_BP and H_SYNC must be nonzero");
  end
  if (V_BP == 0 || V_SYNC == 0) begin : g_v_zero_chk
    $error("V_BP and V_SYNC must be nonzero");
  end
  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_div_chk
    $error("CLK_DIV must be in 1..16");
  end

  localparam logic [DIV_W-1:0] DIV_LAST =
    DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div;
  logic             tick;
  logic             h_wrap;
  logic             v_wrap;
  logic             h_act_nxt;
  logic             v_act_nxt;
  logic             line_q;
  logic             frame_q;

  assign tick   = en && (div == DIV_LAST);
  assign pix_en = rst && tick;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div <= '0;
    end else if (en) begin
      div <= tick ? '0 : div + DIV_W'(1);
    end
  end

  vga_axis_ctr #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (H_POL),
    .W      (CNT_W)
  ) u_h_axis (
    .clk        (clk),
    .rst        (rst),
    .adv        (tick),
    .cnt        (pixel_x),
    .sync       (h_sync),
    .wrap       (h_wrap),
    .active_nxt (h_act_nxt)
  );

  vga_axis_ctr #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (V_POL),
    .W      (CNT_W)
  ) u_v_axis (
    .clk        (clk),
    .rst        (rst),
    .adv        (h_wrap),
    .cnt        (pixel_y),
    .sync       (v_sync),
    .wrap       (v_wrap),
    .active_nxt (v_act_nxt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      video_on <= 1'b0;
      line_q   <= 1'b0;
      frame_q  <= 1'b0;
    end else begin
      video_on <= h_act_nxt && v_act_nxt;
      line_q   <= h_wrap;
      frame_q  <= h_wrap && v_wrap;
    end
  end

  // Pulses are suppressed while timing is frozen.
  assign line_start  = en && line_q;
  assign frame_start = en && frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scenario tasks against constants and
// an arithmetic raster model (ticks -> linear position).
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_d, en_d, rst_r, en_r;
  int errors = 0;
  int checks = 0;

  logic       d_pe, d_hs, d_vs, d_vo, d_ls, d_fs;
  logic [9:0] d_x, d_y;
  logic       p_pe, p_hs, p_vs, p_vo, p_ls, p_fs;
  logic [9:0] p_x, p_y;
  logic       s_pe, s_hs, s_vs, s_vo, s_ls, s_fs;
  logic [2:0] s_x, s_y;
  logic       r_pe, r_hs, r_vs, r_vo, r_ls, r_fs;
  logic [3:0] r_x, r_y;

  typedef struct packed {
    logic pe, hs, vs, vo, ls, fs;
    logic [7:0] x, y;
  } obs_t;

  vga_timing_gen #(
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2)
  ) u_def (
    .clk(clk), .rst(rst_d), .en(en_d),
    .pix_en(d_pe), .h_sync(d_hs), .v_sync(d_vs),
    .pixel_x(d_x), .pixel_y(d_y), .video_on(d_vo),
    .line_start(d_ls), .frame_start(d_fs)
  );

  vga_timing_gen #(
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .H_POL(1'b1), .V_POL(1'b1)
  ) u_pol (
    .clk(clk), .rst(rst_d), .en(en_d),
    .pix_en(p_pe), .h_sync(p_hs), .v_sync(p_vs),
    .pixel_x(p_x), .pixel_y(p_y), .video_on(p_vo),
    .line_start(p_ls), .frame_start(p_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CLK_DIV(1), .CNT_W(3)
  ) u_small (
    .clk(clk), .rst(rst_r), .en(en_r),
    .pix_en(s_pe), .h_sync(s_hs), .v_sync(s_vs),
    .pixel_x(s_x), .pixel_y(s_y), .video_on(s_vo),
    .line_start(s_ls), .frame_start(s_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(5), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .CLK_DIV(3), .CNT_W(4)
  ) u_rnd (
    .clk(clk), .rst(rst_r), .en(en_r),
    .pix_en(r_pe), .h_sync(r_hs), .v_sync(r_vs),
    .pixel_x(r_x), .pixel_y(r_y), .video_on(r_vo),
    .line_start(r_ls), .frame_start(r_fs)
  );

  // ec = enabled clk edges since reset; lt = last edge ticked
  function automatic obs_t model(
    input int ha, hf, hw, hb, va, vf, vw, vb, d, ec,
    input bit en, lt
  );
    int ht, vt, t, lin, x, y;
    obs_t m;
    ht = ha + hf + hw + hb;
    vt = va + vf + vw + vb;
    t  = ec / d;
    if (t == 0) begin
      x = ht - 1;
      y = vt - 1;
    end else begin
      lin = (t - 1) % (ht * vt);
      x = lin % ht;
      y = lin / ht;
    end
    m.pe = en && (ec % d == d - 1);
    m.hs = !(x >= ha + hf && x < ha + hf + hw);
    m.vs = !(y >= va + vf && y < va + vf + vw);
    m.vo = (x < ha) && (y < va);
    m.ls = en && lt && (x == 0);
    m.fs = m.ls && (y == 0);
    m.x  = 8'(x);
    m.y  = 8'(y);
    return m;
  endfunction

  task automatic test_reset();
    int n;
    rst_d = 1'b0; en_d = 1'b1;
    rst_r = 1'b0; en_r = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({d_x, d_y, d_pe, d_hs, d_vs, d_vo, d_ls, d_fs}
        !== {10'd799, 10'd10, 6'b011000}) begin
      errors++;
      $display("FAIL reset_def got=%h exp=%h",
        {d_x, d_y, d_pe, d_hs, d_vs, d_vo, d_ls, d_fs},
        {10'd799, 10'd10, 6'b011000});
    end
    checks++;
    if ({p_x, p_y, p_pe, p_hs, p_vs, p_vo, p_ls, p_fs}
        !== {10'd799, 10'd10, 6'b000000}) begin
      errors++;
      $display("FAIL reset_pol got=%h exp=%h",
        {p_x, p_y, p_pe, p_hs, p_vs, p_vo, p_ls, p_fs},
        {10'd799, 10'd10, 6'b000000});
    end
    rst_d = 1'b1;
    n = 0;
    while (d_pe !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (d_pe !== 1'b1) begin
      errors++;
      $display("FAIL first_pix_en got=%b exp=1", d_pe);
    end
    @(negedge clk);
    checks++;
    if ({d_x, d_y, d_fs, d_vo, d_ls}
        !== {10'd0, 10'd0, 3'b111}) begin
      errors++;
      $display("FAIL first_tick got=%h exp=%h",
        {d_x, d_y, d_fs, d_vo, d_ls},
        {10'd0, 10'd0, 3'b111});
    end
  endtask

  task automatic test_timing();
    int pe_cnt, alt_bad, hs_lo, line_hs, vs_lo, fs_at;
    logic prev_pe;
    pe_cnt = 0; alt_bad = 0; hs_lo = 0;
    line_hs = 0; vs_lo = 0; fs_at = 0;
    prev_pe = d_pe;
    for (int k = 1; k <= 17600; k++) begin
      @(negedge clk);
      pe_cnt += int'(d_pe);
      if (d_pe == prev_pe) alt_bad++;
      prev_pe = d_pe;
      if (!d_hs) hs_lo++;
      if (!d_hs && k <= 1600) line_hs++;
      if (!d_vs) vs_lo++;
      if (d_fs && fs_at == 0) fs_at = k;
      checks++;
      if ({p_pe, p_vo, p_ls, p_fs, p_x, p_y, p_hs, p_vs}
          !== {d_pe, d_vo, d_ls, d_fs, d_x, d_y,
               ~d_hs, ~d_vs}) begin
        errors++;
        $display("FAIL pol_twin k=%0d got=%h exp=%h", k,
          {p_pe, p_vo, p_ls, p_fs, p_x, p_y, p_hs, p_vs},
          {d_pe, d_vo, d_ls, d_fs, d_x, d_y,
           ~d_hs, ~d_vs});
      end
    end
    checks++;
    if (pe_cnt != 8800 || alt_bad != 0) begin
      errors++;
      $display("FAIL pix_en_period got=%0d/%0d exp=8800/0",
        pe_cnt, alt_bad);
    end
    checks++;
    if (line_hs != 192) begin
      errors++;
      $display("FAIL hsync_line got=%0d exp=192", line_hs);
    end
    checks++;
    if (hs_lo != 2112) begin
      errors++;
      $display("FAIL hsync_frame got=%0d exp=2112", hs_lo);
    end
    checks++;
    if (vs_lo != 3200) begin
      errors++;
      $display("FAIL vsync_low got=%0d exp=3200", vs_lo);
    end
    checks++;
    if (fs_at != 17600) begin
      errors++;
      $display("FAIL frame_interval got=%0d exp=17600",
        fs_at);
    end
  endtask

  task automatic test_mid_reset();
    int n;
    n = 0;
    while (!(d_x == 10'd300 && d_y == 10'd5) &&
           n < 40000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(d_x == 10'd300 && d_y == 10'd5)) begin
      errors++;
      $display("FAIL reach_300_5 got=%0d,%0d exp=300,5",
        d_x, d_y);
    end
    #2 rst_d = 1'b0;
    #1;
    checks++;
    if ({d_x, d_y, d_pe, d_hs, d_vs, d_vo, d_ls, d_fs}
        !== {10'd799, 10'd10, 6'b011000}) begin
      errors++;
      $display("FAIL async_reset got=%h exp=%h",
        {d_x, d_y, d_pe, d_hs, d_vs, d_vo, d_ls, d_fs},
        {10'd799, 10'd10, 6'b011000});
    end
    checks++;
    if ({p_hs, p_vs, p_x} !== {2'b00, 10'd799}) begin
      errors++;
      $display("FAIL async_reset_pol got=%h exp=%h",
        {p_hs, p_vs, p_x}, {2'b00, 10'd799});
    end
    repeat (2) @(negedge clk);
    rst_d = 1'b1;
    n = 0;
    while (d_pe !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if ({d_x, d_y, d_fs, d_vo}
        !== {10'd0, 10'd0, 2'b11}) begin
      errors++;
      $display("FAIL restart got=%h exp=%h",
        {d_x, d_y, d_fs, d_vo}, {10'd0, 10'd0, 2'b11});
    end
  endtask

  task automatic test_en_hold();
    int n;
    logic [22:0] snap;
    n = 0;
    while (!(d_x == 10'd655 && d_pe === 1'b1) &&
           n < 4000) begin
      @(negedge clk);
      n++;
    end
    en_d = 1'b0;
    #1;
    checks++;
    if ({d_x, d_hs, d_vo, d_pe}
        !== {10'd655, 3'b100}) begin
      errors++;
      $display("FAIL hold_entry got=%h exp=%h",
        {d_x, d_hs, d_vo, d_pe}, {10'd655, 3'b100});
    end
    snap = {d_x, d_y, d_hs, d_vs, d_vo};
    for (int i = 0; i < 37; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({d_x, d_y, d_hs, d_vs, d_vo, d_pe, d_ls, d_fs}
          !== {snap, 3'b000}) begin
        errors++;
        $display("FAIL frozen i=%0d got=%h exp=%h", i,
          {d_x, d_y, d_hs, d_vs, d_vo, d_pe, d_ls, d_fs},
          {snap, 3'b000});
      end
    end
    en_d = 1'b1;
    #1;
    checks++;
    if ({d_pe, d_hs, d_x} !== {2'b11, 10'd655}) begin
      errors++;
      $display("FAIL resume_tick got=%h exp=%h",
        {d_pe, d_hs, d_x}, {2'b11, 10'd655});
    end
    @(negedge clk);
    checks++;
    if ({d_x, d_hs, p_hs} !== {10'd656, 2'b01}) begin
      errors++;
      $display("FAIL hsync_fall got=%h exp=%h",
        {d_x, d_hs, p_hs}, {10'd656, 2'b01});
    end
  endtask

  task automatic test_random();
    int   ec_s, ec_r;
    bit   lt_s, lt_r;
    obs_t es, er, os, obr;
    ec_s = 0; ec_r = 0; lt_s = 1'b0; lt_r = 1'b0;
    es = model(4, 1, 1, 1, 3, 1, 1, 1, 1, 0, 1'b0, 1'b0);
    os = {s_pe, s_hs, s_vs, s_vo, s_ls, s_fs,
          8'(s_x), 8'(s_y)};
    checks++;
    if (os !== es) begin
      errors++;
      $display("FAIL reset_small got=%h exp=%h", os, es);
    end
    @(negedge clk);
    rst_r = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      en_r = (i < 130) ? 1'b1 : ($urandom_range(0, 3) != 0);
      #1;
      es = model(4, 1, 1, 1, 3, 1, 1, 1, 1,
                 ec_s, en_r, lt_s);
      er = model(5, 2, 3, 1, 4, 1, 2, 2, 3,
                 ec_r, en_r, lt_r);
      os  = {s_pe, s_hs, s_vs, s_vo, s_ls, s_fs,
             8'(s_x), 8'(s_y)};
      obr = {r_pe, r_hs, r_vs, r_vo, r_ls, r_fs,
             8'(r_x), 8'(r_y)};
      checks++;
      if (os !== es) begin
        errors++;
        $display("FAIL small cyc=%0d got=%h exp=%h",
          i, os, es);
      end
      checks++;
      if (obr !== er) begin
        errors++;
        $display("FAIL div3 cyc=%0d got=%h exp=%h",
          i, obr, er);
      end
      lt_s = es.pe;
      lt_r = er.pe;
      if (en_r) begin
        ec_s++;
        ec_r++;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_mid_reset();
    test_en_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks",
      errors, checks);
    $finish;
  end

endmodule
